// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//
// Contents:
//   WORD_W       data word width in bits (32)
//   MAX_LATENCY  largest supported wait-state count (15)
//   CNT_W        width of the wait-state counter
//   dmem_state_e responder FSM state encoding (IDLE, WAIT, RESP)
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram -- single-port word storage, synchronous write, combinational read.
// Contents are not reset; a word is undefined until it is first written.
//
// Ports:
//   clk_i    in   1       clock, rising edge (write timing)
//   we_i     in   1       write enable
//   addr_i   in   ADDR_W  word index (shared by read and write)
//   wdata_i  in   WORD_W  write data
//   rdata_o  out  WORD_W  mem[addr_i], combinational
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp -- fixed-latency data-memory responder.
//
// A request is accepted on a rising edge with req_i=1 while ready_o=1; the
// access then spends LATENCY cycles in WAIT and one cycle in RESP, where a
// single-cycle rvalid_o strobe carries the load data (or store echo).
// Requests seen while ready_o=0 are dropped, never queued.
//
// Handshake: ready_o is high only in IDLE; an accept is req_i & ready_o at a
// rising clk_i edge. rvalid_o is high for exactly one cycle (RESP) per accept;
// rdata_o32 and err_o are zero whenever rvalid_o is zero.
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag accesses whose byte
// address is not word aligned (err_o=1, rdata_o32=0, no memory write).
// Without it, addr_i32[1:0] is ignored and err_o is constant 0.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   reset_i      in   1   asynchronous active-high reset
//   req_i        in   1   access request
//   we_i         in   1   1 = store, 0 = load
//   addr_i32     in   32  byte address (word index = addr[log2(DEPTH)+1:2])
//   wdata_i32    in   32  store data
//   ready_o      out  1   can accept a request this cycle
//   rvalid_o     out  1   one-cycle response strobe
//   rdata_o32    out  32  load data or store echo, 0 when rvalid_o=0
//   err_o        out  1   access error, qualified by rvalid_o
//   dbg_state_o  out  2   current FSM state (observability)
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i32,
    input  logic [31:0]       wdata_i32,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o32,
    output logic              err_o,
    output dmem_state_e       dbg_state_o
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [WORD_W-1:0]  ram_rdata;
    logic               ram_we;
    logic               misalign;
    logic               accept;
    logic               wait_done;

    assign accept      = (state == ST_IDLE) && req_i;
    assign wait_done   = (state == ST_WAIT) && (cnt == '0);
    assign dbg_state_o = state;

    // The store lands on the edge that leaves WAIT; an aborted access never
    // reaches that edge because reset forces IDLE.
    assign ram_we = wait_done && we_q && !misalign;

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ready_o   <= 1'b1;
            rvalid_o  <= 1'b0;
            rdata_o32 <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_i32[IDX_W+1:2];
                        wdata_q <= wdata_i32;
                        cnt     <= CNT_LOAD;
                        ready_o <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        // Response data is registered here so it is stable for
                        // the whole RESP cycle. A store echoes its own data.
                        rvalid_o <= 1'b1;
                        if (misalign) begin
                            rdata_o32 <= '0;
                        end else if (we_q) begin
                            rdata_o32 <= wdata_q;
                        end else begin
                            rdata_o32 <= ram_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    rvalid_o  <= 1'b0;
                    rdata_o32 <= '0;
                    ready_o   <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    rvalid_o  <= 1'b0;
                    rdata_o32 <= '0;
                    ready_o   <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Address bits outside the word index never influence the access.
    logic unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mis_q <= 1'b0;
            err_o <= 1'b0;
        end else if (accept) begin
            mis_q <= (addr_i32[1:0] != 2'b00);
        end else if (wait_done) begin
            err_o <= mis_q;
        end else if (state == ST_RESP) begin
            err_o <= 1'b0;
        end
    end

    assign misalign    = mis_q;
    assign unused_addr = ^addr_i32[31:IDX_W+2];
`else
    assign misalign    = 1'b0;
    assign err_o       = 1'b0;
    assign unused_addr = ^{addr_i32[31:IDX_W+2], addr_i32[1:0], accept};
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp -- directed self-checking bench for data_mem_resp
// (DEPTH=64, LATENCY=2). Expectations for the alignment scenario follow the
// DMEM_ALIGN_CHECK_EN macro as seen by this compilation.
module tb_data_mem_resp;
    import dmem_pkg::*;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    dmem_state_e dbg_state;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    data_mem_resp #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .we_i        (we),
        .addr_i32    (addr),
        .wdata_i32   (wdata),
        .ready_o     (ready),
        .rvalid_o    (rvalid),
        .rdata_o32   (rdata),
        .err_o       (err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- driver ----------------
    // One complete access. lat is the number of negedges after the accepting
    // edge at which rvalid is first seen (-1 on timeout). bad counts protocol
    // violations: outputs not idle while waiting, or rvalid/rdata/err not
    // dropping back after the single response cycle.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] rd, output logic er,
                             output int bad);
        int n;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        bad = 0;
        n   = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) return;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        // Scramble inputs: the captured access must not follow them.
        req   = 1'b0;
        we    = ~w;
        addr  = 32'hFFFF_FFFC;
        wdata = 32'h0BAD_0BAD;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rvalid) begin
                lat = k;
                rd  = rdata;
                er  = err;
                @(negedge clk);
                if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || ready !== 1'b1) bad++;
                break;
            end else if (ready !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
                bad++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int lat, bad;
        logic [31:0] rd;
        logic er;
        do_access(1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er, bad);
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL st_latency: got %0d expected %0d", lat, LATENCY + 1); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_echo: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL st_err: got %b expected 0", er); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL st_protocol: got %0d violations expected 0", bad); end
        do_access(1'b0, 32'h10, 32'h0, lat, rd, er, bad);
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL ld_latency: got %0d expected %0d", lat, LATENCY + 1); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_data: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_err: got %b expected 0", er); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL ld_protocol: got %0d violations expected 0", bad); end
    endtask

    // req held high across four stores; the scoreboard checks order, data,
    // spacing between accepts and response latency.
    task automatic test_back_to_back();
        logic [31:0] vec [4] = '{32'h0101_0101, 32'h2222_0202, 32'h3030_3333, 32'h4444_4444};
        logic [31:0] exp_q[$];
        int          acc_q[$];
        int          k = 0, last_acc = 0, gap_bad = 0, lat_bad = 0, data_bad = 0, resp_cnt = 0;
        int          lat, bad;
        logic [31:0] rd, exp_d;
        logic        er;
        int          a;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (rvalid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    data_bad++;
                end else begin
                    exp_d = exp_q.pop_front();
                    a     = acc_q.pop_front();
                    if (rdata !== exp_d) data_bad++;
                    if (cyc - a != LATENCY + 1) lat_bad++;
                end
            end
            if (ready && k < 4) begin
                if (k > 0 && cyc - last_acc != LATENCY + 2) gap_bad++;
                last_acc = cyc;
                req   = 1'b1;
                we    = 1'b1;
                addr  = 32'h40 + 32'(4 * k);
                wdata = vec[k];
                exp_q.push_back(vec[k]);
                acc_q.push_back(cyc);
                k++;
            end else if (ready) begin
                req = 1'b0;
            end else begin
                we    = 1'b0;
                addr  = 32'h0000_00FC;
                wdata = 32'hBAD0_0000 + 32'(cyc);
            end
        end
        req = 1'b0;
        checks++; if (k !== 4) begin failures++; $display("FAIL b2b_accepts: got %0d expected 4", k); end
        checks++; if (resp_cnt !== 4) begin failures++; $display("FAIL b2b_responses: got %0d expected 4", resp_cnt); end
        checks++; if (gap_bad !== 0) begin failures++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); end
        checks++; if (lat_bad !== 0) begin failures++; $display("FAIL b2b_latency: got %0d bad latencies expected 0", lat_bad); end
        checks++; if (data_bad !== 0) begin failures++; $display("FAIL b2b_data: got %0d bad responses expected 0", data_bad); end
        do_access(1'b0, 32'h48, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'h3030_3333) begin failures++; $display("FAIL b2b_readback: got %h expected 30303333", rd); end
    endtask

    task automatic test_wrap();
        int lat, bad;
        logic [31:0] rd;
        logic er;
        do_access(1'b1, 32'h104, 32'h1111_1111, lat, rd, er, bad);
        do_access(1'b0, 32'h004, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'h1111_1111) begin failures++; $display("FAIL wrap_data: got %h expected 11111111", rd); end
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL wrap_latency: got %0d expected %0d", lat, LATENCY + 1); end
    endtask

    task automatic test_reset_abort();
        int lat, bad, seen = 0, n = 0;
        logic [31:0] rd;
        logic er;
        do_access(1'b1, 32'h20, 32'h1234_5678, lat, rd, er, bad);
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL abort_in_wait: got %0d expected %0d", dbg_state, ST_WAIT); end
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", ready); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_resp: got %0d strobes expected 0", seen); end
        do_access(1'b0, 32'h20, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL abort_mem_kept: got %h expected 12345678", rd); end
    endtask

    task automatic test_align();
        int lat, bad;
        logic [31:0] rd;
        logic er;
        do_access(1'b1, 32'h20, 32'h5555_5555, lat, rd, er, bad);
        do_access(1'b1, 32'h22, 32'hCAFE_F00D, lat, rd, er, bad);
        checks++; if (lat !== LATENCY + 1) begin failures++; $display("FAIL align_latency: got %0d expected %0d", lat, LATENCY + 1); end
`ifdef DMEM_ALIGN_CHECK_EN
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL align_err: got %b expected 1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL align_rdata: got %h expected 00000000", rd); end
        do_access(1'b0, 32'h20, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'h5555_5555) begin failures++; $display("FAIL align_mem: got %h expected 55555555", rd); end
`else
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL align_err: got %b expected 0", er); end
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL align_rdata: got %h expected cafef00d", rd); end
        do_access(1'b0, 32'h20, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL align_mem: got %h expected cafef00d", rd); end
`endif
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL align_load_err: got %b expected 0", er); end
    endtask

    // Extra requests pulsed while busy must be dropped, not queued.
    task automatic test_ignore_busy();
        int lat, bad, n = 0, resp = 0, extra = 0;
        logic [31:0] rd, got = '0;
        logic er;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h30;
        wdata = 32'h7777_7777;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int k = 1; k <= LATENCY + 1; k++) begin
            @(negedge clk);
            if (rvalid) begin
                resp++;
                got = rdata;
            end
            // Pulse a conflicting request for one cycle in WAIT and RESP.
            req   = 1'b1;
            we    = 1'b1;
            addr  = 32'h34;
            wdata = 32'h9999_9999;
            @(posedge clk);
            #1;
            req = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid) extra++;
        end
        checks++; if (resp !== 1) begin failures++; $display("FAIL busy_one_resp: got %0d expected 1", resp); end
        checks++; if (got !== 32'h7777_7777) begin failures++; $display("FAIL busy_data: got %h expected 77777777", got); end
        checks++; if (extra !== 0) begin failures++; $display("FAIL busy_not_queued: got %0d strobes expected 0", extra); end
        do_access(1'b0, 32'h30, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'h7777_7777) begin failures++; $display("FAIL busy_mem30: got %h expected 77777777", rd); end
        do_access(1'b1, 32'h34, 32'h6666_6666, lat, rd, er, bad);
        do_access(1'b0, 32'h34, 32'h0, lat, rd, er, bad);
        checks++; if (rd !== 32'h6666_6666) begin failures++; $display("FAIL busy_mem34: got %h expected 66666666", rd); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_wrap();
        test_reset_abort();
        test_align();
        test_ignore_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit memory words (a power of two, minimum 4).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait-state cycles per access (range 1..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous active-high reset.
- req_i  in  1  access request from the datapath.
- we_i  in  1  1 = store word, 0 = load word.
- addr_i32  in  32  byte address.
- wdata_i32  in  32  store data.
- ready_o  out  1  responder can accept a request this cycle.
- rvalid_o  out  1  one-cycle response strobe.
- rdata_o32  out  32  load data, or store echo.
- err_o  out  1  access error, qualified by rvalid_o.

Function
REQ-004 Handshake: a request SHALL be accepted on a rising edge where req_i and ready_o are both 1; req_i while ready_o is 0 SHALL be ignored and not queued.
REQ-005 On accept, the block SHALL capture we_i, addr_i32 and wdata_i32; later input changes SHALL NOT affect the access in flight.
REQ-006 The FSM SHALL have states IDLE, WAIT and RESP.
- IDLE -> WAIT on accept, with the wait counter loaded to LATENCY-1.
- WAIT decrements the counter each cycle and goes to RESP when the counter is 0.
- RESP -> IDLE unconditionally.
REQ-007 ready_o SHALL be 1 only in IDLE; rvalid_o SHALL be 1 only in RESP.
REQ-008 Latency: rvalid_o SHALL assert exactly LATENCY+1 cycles after the accepting edge; back-to-back accepts SHALL be at least LATENCY+2 cycles apart.
REQ-009 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-010 A store SHALL write the memory on the edge leaving WAIT; in RESP, rdata_o32 SHALL equal the stored data.
REQ-011 A load SHALL present mem[index] on rdata_o32 in RESP; when rvalid_o is 0, rdata_o32 SHALL be 0.
REQ-012 A load following a store to the same word SHALL return the new data.
REQ-013 err_o SHALL be 0 whenever rvalid_o is 0.

Reset
REQ-014 Asserting reset_i SHALL asynchronously force IDLE, the counter to 0, rvalid_o=0, rdata_o32=0, err_o=0 and ready_o=1.
REQ-015 Reset during WAIT or RESP SHALL abort the access: no memory write if still in WAIT, and no response is produced.
REQ-016 Memory contents SHALL NOT be cleared by reset; they are undefined until first written.

Configuration
REQ-017 Macro DMEM_ALIGN_CHECK_EN defined: an access with addr[1:0] != 0 SHALL complete with normal timing, assert err_o in RESP, return rdata_o32=0, and suppress any memory write.
REQ-018 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored, err_o SHALL be tied to 0, and no alignment logic SHALL be built.

Structure
REQ-019 Package dmem_pkg SHALL hold the FSM state enum typedef, the word width constant (32) and the maximum LATENCY constant.
REQ-020 The storage array SHALL be a sub-module dmem_ram with a single port, synchronous write and combinational read, parameterised by DEPTH.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Store 0xDEADBEEF at 0x10, then load 0x10 -> rvalid_o on cycle LATENCY+1 after each accept; load returns 0xDEADBEEF, err_o=0.
- req_i held high continuously -> accepts exactly LATENCY+2 cycles apart; no request lost or duplicated.
- DEPTH=64: store 0x11111111 at 0x104, then load 0x004 -> 0x11111111 (wrap-around).
- Reset asserted mid-WAIT of a store of 0xA5A5A5A5 to 0x20 -> no rvalid_o; ready_o=1 immediately; a later load of 0x20 returns the prior value.
- DMEM_ALIGN_CHECK_EN defined: store to 0x22 -> err_o=1, rdata_o32=0, word 0x20 unchanged; without the macro, the same store writes word 0x20 and err_o=0.
- req_i pulsed during WAIT and RESP -> ignored; the response carries the first request's data only.
